// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the BCD stopwatch tick counter.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_PAUSED  = 2'd2
    } sw_state_e;

    localparam int unsigned BCD_W = 4;
    typedef logic [BCD_W-1:0] bcd_t;

    // Highest value of a decimal digit and of the seconds-tens digit
    localparam int unsigned DIG_MAX_ONES     = 9;
    localparam int unsigned DIG_MAX_SEC_TENS = 5;

    // MM:SS.cc
    localparam int unsigned DIGITS = 6;

    typedef struct packed {
        bcd_t min_tens;
        bcd_t min_ones;
        bcd_t sec_tens;
        bcd_t sec_ones;
        bcd_t cs_tens;
        bcd_t cs_ones;
    } sw_time_t;

    // Tens and ones BCD digits of a small decimal value (0..99)
    function automatic bcd_t bcd_tens(input int unsigned v);
        return BCD_W'(v / 10);
    endfunction

    function automatic bcd_t bcd_ones(input int unsigned v);
        return BCD_W'(v % 10);
    endfunction

endpackage

// File: rtl/stopwatch_tick_counter_bcd_digit_counter.sv
// Single BCD digit cell: counts 0..MAX_VAL on inc, signals carry when it rolls over.
module bcd_digit_counter
    import stopwatch_pkg::*;
#(
    parameter int unsigned MAX_VAL = DIG_MAX_ONES
) (
    input  logic clk_in,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output bcd_t digit,
    output logic carry_out
);

    bcd_t digit_q;
    bcd_t digit_d;
    logic at_max;

    assign at_max = (digit_q == BCD_W'(MAX_VAL));

    // Next digit value: clear wins over increment, roll to zero past MAX_VAL
    always_comb begin
        digit_d = digit_q;
        if (clr) begin
            digit_d = '0;
        end else if (inc) begin
            digit_d = at_max ? '0 : digit_q + BCD_W'(1);
        end
    end

    // Digit register
    always_ff @(posedge clk_in) begin
        if (reset) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit     = digit_q;
    assign carry_out = inc && at_max;

endmodule

// File: rtl/stopwatch_tick_counter.sv
// BCD stopwatch MM:SS.cc driven by 100 Hz tick pulses, with start/stop/clear and lap hold.
module stopwatch_tick_counter
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1,
    parameter int unsigned MAX_MIN  = 59
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       tick_in,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       lap,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [3:0] cs_tens,
    output logic [3:0] cs_ones,
    output logic       running,
    output logic       held,
    output logic       wrap
);

    localparam int unsigned PRE_W = 8;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam bcd_t MIN_T_MAX = bcd_tens(MAX_MIN);
    localparam bcd_t MIN_O_MAX = bcd_ones(MAX_MIN);

    sw_state_e        state_q;
    logic [PRE_W-1:0] presc_q;
    logic [PRE_W-1:0] presc_d;
    logic             running_q;
    logic             held_q;
    logic             wrap_q;
    sw_time_t         snap_q;

    sw_time_t         live;
    sw_time_t         disp;
    bcd_t             live_cs_ones;
    bcd_t             live_cs_tens;
    bcd_t             live_sec_ones;
    bcd_t             live_sec_tens;
    bcd_t             live_min_ones;
    bcd_t             live_min_tens;
    logic [DIGITS-1:0] carry;

    logic             count_en;
    logic             adv;
    logic             min_at_max;
    logic             min_wrap;
    logic             min_clr;

    // Only the registered state gates counting; clear discards the tick
    assign count_en = (state_q == ST_RUNNING) && tick_in && !clear;

    // Prescaler: advance centiseconds on the tick that completes TICK_DIV
    always_comb begin
        presc_d = presc_q;
        adv     = 1'b0;
        if (count_en) begin
            if (presc_q == PRE_LAST) begin
                presc_d = '0;
                adv     = 1'b1;
            end else begin
                presc_d = presc_q + PRE_W'(1);
            end
        end
    end

    // Minutes wrap at MAX_MIN; the tens-cell carry is only reachable at 99
    assign min_at_max = (live_min_tens == MIN_T_MAX) && (live_min_ones == MIN_O_MAX);
    assign min_wrap   = carry[3] && (min_at_max || carry[5]);
    assign min_clr    = clear || min_wrap;

    bcd_digit_counter #(.MAX_VAL(DIG_MAX_ONES)) u_cs_ones (
        .clk_in    (clk_in),
        .reset     (reset),
        .clr       (clear),
        .inc       (adv),
        .digit     (live_cs_ones),
        .carry_out (carry[0])
    );

    bcd_digit_counter #(.MAX_VAL(DIG_MAX_ONES)) u_cs_tens (
        .clk_in    (clk_in),
        .reset     (reset),
        .clr       (clear),
        .inc       (carry[0]),
        .digit     (live_cs_tens),
        .carry_out (carry[1])
    );

    bcd_digit_counter #(.MAX_VAL(DIG_MAX_ONES)) u_sec_ones (
        .clk_in    (clk_in),
        .reset     (reset),
        .clr       (clear),
        .inc       (carry[1]),
        .digit     (live_sec_ones),
        .carry_out (carry[2])
    );

    bcd_digit_counter #(.MAX_VAL(DIG_MAX_SEC_TENS)) u_sec_tens (
        .clk_in    (clk_in),
        .reset     (reset),
        .clr       (clear),
        .inc       (carry[2]),
        .digit     (live_sec_tens),
        .carry_out (carry[3])
    );

    bcd_digit_counter #(.MAX_VAL(DIG_MAX_ONES)) u_min_ones (
        .clk_in    (clk_in),
        .reset     (reset),
        .clr       (min_clr),
        .inc       (carry[3]),
        .digit     (live_min_ones),
        .carry_out (carry[4])
    );

    bcd_digit_counter #(.MAX_VAL(DIG_MAX_ONES)) u_min_tens (
        .clk_in    (clk_in),
        .reset     (reset),
        .clr       (min_clr),
        .inc       (carry[4]),
        .digit     (live_min_tens),
        .carry_out (carry[5])
    );

    assign live = '{
        min_tens: live_min_tens,
        min_ones: live_min_ones,
        sec_tens: live_sec_tens,
        sec_ones: live_sec_ones,
        cs_tens:  live_cs_tens,
        cs_ones:  live_cs_ones
    };

    // Control FSM, prescaler, lap snapshot and registered status outputs
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            presc_q   <= '0;
            running_q <= 1'b0;
            held_q    <= 1'b0;
            wrap_q    <= 1'b0;
            snap_q    <= '0;
        end else begin
            wrap_q  <= min_wrap;
            presc_q <= presc_d;
            if (clear) begin
                state_q   <= ST_IDLE;
                running_q <= 1'b0;
                presc_q   <= '0;
                held_q    <= 1'b0;
                snap_q    <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start) begin
                            state_q   <= ST_RUNNING;
                            running_q <= 1'b1;
                            presc_q   <= '0;
                        end
                    end
                    ST_RUNNING: begin
                        if (stop) begin
                            state_q   <= ST_PAUSED;
                            running_q <= 1'b0;
                        end else if (lap) begin
                            if (held_q) begin
                                held_q <= 1'b0;
                            end else begin
                                snap_q <= live;
                                held_q <= 1'b1;
                            end
                        end
                    end
                    ST_PAUSED: begin
                        if (start) begin
                            state_q   <= ST_RUNNING;
                            running_q <= 1'b1;
                        end else if (lap && held_q) begin
                            held_q <= 1'b0;
                        end
                    end
                    default: begin
                        state_q   <= ST_IDLE;
                        running_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Display shows the lap snapshot while held, live count otherwise
    assign disp = held_q ? snap_q : live;

    assign min_tens = disp.min_tens;
    assign min_ones = disp.min_ones;
    assign sec_tens = disp.sec_tens;
    assign sec_ones = disp.sec_ones;
    assign cs_tens  = disp.cs_tens;
    assign cs_ones  = disp.cs_ones;
    assign running  = running_q;
    assign held     = held_q;
    assign wrap     = wrap_q;

endmodule

// File: tb/tb_stopwatch_tick_counter.sv
// Directed bench: default instance, TICK_DIV=4 instance, MAX_MIN=1 instance for wrap.
module tb_stopwatch_tick_counter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tick_in = 1'b0;
    logic start = 1'b0;
    logic stop = 1'b0;
    logic clear = 1'b0;
    logic lap = 1'b0;

    logic [3:0] mt0, mo0, st0, so0, ct0, co0;
    logic [3:0] mt1, mo1, st1, so1, ct1, co1;
    logic [3:0] mt2, mo2, st2, so2, ct2, co2;
    logic       run0, held0, wrap0;
    logic       run1, held1, wrap1;
    logic       run2, held2, wrap2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stopwatch_tick_counter u0 (
        .clk_in(clk), .reset(reset), .tick_in(tick_in), .start(start), .stop(stop),
        .clear(clear), .lap(lap),
        .min_tens(mt0), .min_ones(mo0), .sec_tens(st0), .sec_ones(so0),
        .cs_tens(ct0), .cs_ones(co0), .running(run0), .held(held0), .wrap(wrap0)
    );

    stopwatch_tick_counter #(.TICK_DIV(4)) u1 (
        .clk_in(clk), .reset(reset), .tick_in(tick_in), .start(start), .stop(stop),
        .clear(clear), .lap(lap),
        .min_tens(mt1), .min_ones(mo1), .sec_tens(st1), .sec_ones(so1),
        .cs_tens(ct1), .cs_ones(co1), .running(run1), .held(held1), .wrap(wrap1)
    );

    stopwatch_tick_counter #(.MAX_MIN(1)) u2 (
        .clk_in(clk), .reset(reset), .tick_in(tick_in), .start(start), .stop(stop),
        .clear(clear), .lap(lap),
        .min_tens(mt2), .min_ones(mo2), .sec_tens(st2), .sec_ones(so2),
        .cs_tens(ct2), .cs_ones(co2), .running(run2), .held(held2), .wrap(wrap2)
    );

    // Displayed time as 24-bit hex that reads as MMSScc
    wire [23:0] d0 = {mt0, mo0, st0, so0, ct0, co0};
    wire [23:0] d1 = {mt1, mo1, st1, so1, ct1, co1};
    wire [23:0] d2 = {mt2, mo2, st2, so2, ct2, co2};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One edge with the given pulses, then drop them; sample 1 time unit after the edge
    task automatic pulse(input logic s, input logic p, input logic c, input logic l, input logic t);
        start = s; stop = p; clear = c; lap = l; tick_in = t;
        @(posedge clk);
        #1;
        start = 1'b0; stop = 1'b0; clear = 1'b0; lap = 1'b0; tick_in = 1'b0;
    endtask

    task automatic ticks(input int n);
        tick_in = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        tick_in = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_digits", 32'(d0), 32'h000000);
        check("rst_running", 32'(run0), 32'd0);
        check("rst_held", 32'(held0), 32'd0);
        check("rst_wrap", 32'(wrap0), 32'd0);

        // Start then 250 ticks -> 00:02.50
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("start_running", 32'(run0), 32'd1);
        ticks(250);
        check("t250_digits", 32'(d0), 32'h000250);
        check("t250_running", 32'(run0), 32'd1);
        check("t250_wrap", 32'(wrap0), 32'd0);

        // Carry into seconds and into minutes
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("clear_digits", 32'(d0), 32'h000000);
        check("clear_running", 32'(run0), 32'd0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        ticks(99);
        check("at_0099", 32'(d0), 32'h000099);
        ticks(1);
        check("carry_sec", 32'(d0), 32'h000100);
        ticks(5899);
        check("at_5999", 32'(d0), 32'h005999);
        ticks(1);
        check("carry_min", 32'(d0), 32'h010000);

        // Lap hold freezes display while counting continues
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        ticks(300);
        check("pre_lap", 32'(d0), 32'h000300);
        pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("lap_held", 32'(held0), 32'd1);
        ticks(100);
        check("lap_frozen", 32'(d0), 32'h000300);
        check("lap_still_held", 32'(held0), 32'd1);
        pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("unlap_held", 32'(held0), 32'd0);
        check("unlap_live", 32'(d0), 32'h000400);

        // Wrap at MAX_MIN:59.99 (u2 has MAX_MIN=1); u0 keeps counting past it
        do_reset();
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        ticks(11999);
        check("pre_wrap", 32'(d2), 32'h015999);
        check("pre_wrap_flag", 32'(wrap2), 32'd0);
        ticks(1);
        check("wrap_digits", 32'(d2), 32'h000000);
        check("wrap_pulse", 32'(wrap2), 32'd1);
        check("wrap_running", 32'(run2), 32'd1);
        check("nowrap_u0", 32'(d0), 32'h020000);
        check("nowrap_u0_flag", 32'(wrap0), 32'd0);
        pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("wrap_one_cycle", 32'(wrap2), 32'd0);
        check("wrap_then_hold", 32'(d2), 32'h000000);

        // TICK_DIV=4: prescaler preserved across pause
        do_reset();
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        ticks(6);
        check("div4_6ticks", 32'(d1), 32'h000001);
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("div4_paused", 32'(run1), 32'd0);
        ticks(10);
        check("div4_paused_ticks", 32'(d1), 32'h000001);
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        ticks(2);
        check("div4_resume", 32'(d1), 32'h000002);

        // start+stop+clear together while running -> idle, zeroed
        do_reset();
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        ticks(500);
        check("at_0500", 32'(d0), 32'h000500);
        pulse(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check("ssc_digits", 32'(d0), 32'h000000);
        check("ssc_running", 32'(run0), 32'd0);

        // start and tick on the same edge from idle: tick not counted
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("start_tick_digits", 32'(d0), 32'h000000);
        check("start_tick_running", 32'(run0), 32'd1);

        // stop and tick on the same edge: tick counted
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        check("stop_tick_digits", 32'(d0), 32'h000001);
        check("stop_tick_running", 32'(run0), 32'd0);

        // lap while paused and not held is ignored
        pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("paused_lap_ignored", 32'(held0), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
